// File: rtl/modulo_escalonador_divisor_pkg.sv
// Shared types and constants for the divided-clock tick scheduler.
package modulo_escalonador_pkg;

  localparam int OVR_W = 8;
  localparam logic [OVR_W-1:0] OVR_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    ALIGN   = 2'd2,
    RUN     = 2'd3
  } state_t;

  // True when more than one requester is asking at once (req zero-extended to 8 bits).
  function automatic logic multi_bit(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/modulo_escalonador_divisor_if.sv
// Divider-side and requester-side signals of the scheduler, grouped for port connection.
interface modulo_escalonador_divisor_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                                  en;
  logic                                  clk_div;
  logic                                  div_clr;
  logic [N_REQ-1:0]                      req;
  logic [N_REQ-1:0]                      gnt;
  logic [IDW-1:0]                        gnt_id;
  logic                                  tick;
  logic                                  busy;
  logic [modulo_escalonador_pkg::OVR_W-1:0] ovr_cnt;

  modport master (
    output en, clk_div, req,
    input  div_clr, gnt, gnt_id, tick, busy, ovr_cnt
  );

  modport slave (
    input  en, clk_div, req,
    output div_clr, gnt, gnt_id, tick, busy, ovr_cnt
  );

endinterface

// File: rtl/modulo_escalonador_divisor_sincronizador.sv
// Brings the asynchronous clk_div into the clock domain and registers its rising edge.
module modulo_sincronizador #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_flush,
  input  logic i_d,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge i_clk) begin
    if (!i_clr || i_flush) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/modulo_escalonador_divisor.sv
// Divider sequencer and round-robin tick distributor.
// Define ESCALONADOR_OVERRUN_EN to build the saturating overrun counter.
module modulo_escalonador_divisor
  import modulo_escalonador_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int RESTART_CYC = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic                        i_clk,
  input logic                        i_clr,
  modulo_escalonador_divisor_if.slave s_if
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = (RESTART_CYC > 1) ? $clog2(RESTART_CYC + 1) : 1;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_div_clr, r_busy;
  logic             w_rise, w_flush, w_hit;
  logic [IDW-1:0]   w_idx;

  assign w_flush = (r_state == RESTART);

  modulo_sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sinc (
    .i_clk  (i_clk),
    .i_clr  (i_clr),
    .i_flush(w_flush),
    .i_d    (s_if.clk_div),
    .o_rise (w_rise)
  );

  // First set request at or after the pointer, wrapping past N_REQ-1.
  always_comb begin : arb
    int             k;
    logic [IDW-1:0] v_k;
    k     = 0;
    v_k   = '0;
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(r_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      v_k = IDW'(k);
      if (!w_hit && s_if.req[v_k]) begin
        w_hit = 1'b1;
        w_idx = v_k;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ptr_nxt    = r_ptr;
    w_gnt_id_nxt = r_gnt_id;
    w_gnt_nxt    = '0;
    w_tick_nxt   = 1'b0;
    if (!s_if.en) begin
      w_state_nxt = IDLE;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = RESTART;
          w_cnt_nxt   = CW'(RESTART_CYC - 1);
        end
        RESTART: begin
          if (r_cnt == '0) w_state_nxt = ALIGN;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        ALIGN: begin
          if (w_rise) w_state_nxt = RUN;
        end
        RUN: begin
          if (w_rise) begin
            w_tick_nxt = 1'b1;
            if (w_hit) begin
              w_gnt_nxt    = N_REQ'(1) << w_idx;
              w_gnt_id_nxt = w_idx;
              w_ptr_nxt    = (w_idx == IDW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_gnt_id  <= '0;
      r_gnt     <= '0;
      r_tick    <= 1'b0;
      r_div_clr <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_gnt     <= w_gnt_nxt;
      r_tick    <= w_tick_nxt;
      r_div_clr <= (w_state_nxt == ALIGN) || (w_state_nxt == RUN);
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

`ifdef ESCALONADOR_OVERRUN_EN
  logic [OVR_W-1:0] r_ovr;

  always_ff @(posedge i_clk) begin
    if (!i_clr || w_state_nxt == IDLE) begin
      r_ovr <= '0;
    end else if (r_state == RUN && w_rise && multi_bit(8'(s_if.req)) && r_ovr != OVR_MAX) begin
      r_ovr <= r_ovr + 1'b1;
    end
  end

  assign s_if.ovr_cnt = r_ovr;
`else
  assign s_if.ovr_cnt = '0;
`endif

  assign s_if.div_clr = r_div_clr;
  assign s_if.gnt     = r_gnt;
  assign s_if.gnt_id  = r_gnt_id;
  assign s_if.tick    = r_tick;
  assign s_if.busy    = r_busy;

endmodule

// File: tb/tb_modulo_escalonador_divisor.sv
// Directed self-checking bench for the divided-clock tick scheduler.
module tb_modulo_escalonador_divisor;

`ifdef ESCALONADOR_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  modulo_escalonador_divisor_if #(.N_REQ(4)) u_if ();

  modulo_escalonador_divisor #(
    .N_REQ(4), .RESTART_CYC(2), .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_clr(clr),
    .s_if (u_if.slave)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // en is (or stays) high; divider held in clear for exactly two cycles, then released.
  task automatic start_seq();
    u_if.en = 1'b1;
    cyc(1); chk("restart_busy", u_if.busy, 1'b1); chk("restart_clr0", u_if.div_clr, 1'b0);
    cyc(1); chk("restart_clr1", u_if.div_clr, 1'b0);
    cyc(1); chk("align_clr", u_if.div_clr, 1'b1);
  endtask

  // One clk_div period: 4 cycles high, 4 low; tick lands 4 slots after the rise is driven.
  task automatic pulse(input logic [3:0] r, input logic et, input logic [3:0] eg, input logic [1:0] eid);
    u_if.req     = r;
    u_if.clk_div = 1'b1;
    cyc(3); chk("pre_tick", u_if.tick, 1'b0);
    cyc(1); chk("tick", u_if.tick, et); chk("gnt", u_if.gnt, eg); chk("gnt_id", u_if.gnt_id, eid);
    u_if.clk_div = 1'b0;
    cyc(1); chk("tick_width", {u_if.gnt, u_if.tick}, 5'd0);
    cyc(3);
  endtask

  task automatic chk_reset_outs();
    chk("rst_div_clr", u_if.div_clr, 1'b0);
    chk("rst_gnt", u_if.gnt, 4'd0);
    chk("rst_gnt_id", u_if.gnt_id, 2'd0);
    chk("rst_tick", u_if.tick, 1'b0);
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_ovr", u_if.ovr_cnt, 8'd0);
  endtask

  initial begin
    logic [3:0] seq_gnt [8];
    seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    clr          = 1'b0;
    u_if.en      = 1'b0;
    u_if.clk_div = 1'b0;
    u_if.req     = 4'd0;
    cyc(2);
    chk_reset_outs();

    clr = 1'b1;
    start_seq();
    pulse(4'b1111, 1'b0, 4'b0000, 2'd0);

    for (int i = 0; i < 8; i++) pulse(4'b1111, 1'b1, seq_gnt[i], 2'(i));
    chk("ovr_after_8", u_if.ovr_cnt, OVR_ON ? 8'd8 : 8'd0);

    pulse(4'b1010, 1'b1, 4'b0010, 2'd1);
    pulse(4'b1010, 1'b1, 4'b1000, 2'd3);
    pulse(4'b1010, 1'b1, 4'b0010, 2'd1);
    pulse(4'b0000, 1'b1, 4'b0000, 2'd1);
    pulse(4'b1111, 1'b1, 4'b0100, 2'd2);
    chk("ovr_after_mix", u_if.ovr_cnt, OVR_ON ? 8'd12 : 8'd0);

    pulse(4'b0100, 1'b1, 4'b0100, 2'd2);
    pulse(4'b0100, 1'b1, 4'b0100, 2'd2);

    // Drop en in the very cycle a tick would have been registered.
    u_if.req     = 4'b1111;
    u_if.clk_div = 1'b1;
    cyc(3);
    u_if.en = 1'b0;
    cyc(1);
    chk("drop_tick", u_if.tick, 1'b0);
    chk("drop_gnt", u_if.gnt, 4'd0);
    chk("drop_busy", u_if.busy, 1'b0);
    chk("drop_div_clr", u_if.div_clr, 1'b0);
    chk("drop_gnt_id", u_if.gnt_id, 2'd2);
    chk("drop_ovr", u_if.ovr_cnt, 8'd0);
    u_if.clk_div = 1'b0;
    cyc(4);

    start_seq();
    pulse(4'b1111, 1'b0, 4'b0000, 2'd2);
    pulse(4'b1111, 1'b1, 4'b0001, 2'd0);
    for (int i = 0; i < 36; i++)
      pulse(4'b0011, 1'b1, (i % 2 == 0) ? 4'b0010 : 4'b0001, (i % 2 == 0) ? 2'd1 : 2'd0);
    chk("ovr_37", u_if.ovr_cnt, OVR_ON ? 8'd37 : 8'd0);

    clr = 1'b0;
    cyc(1);
    chk_reset_outs();
    clr = 1'b1;

    start_seq();
    pulse(4'b0011, 1'b0, 4'b0000, 2'd0);
    for (int i = 0; i < 300; i++)
      pulse(4'b0011, 1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0010, (i % 2 == 0) ? 2'd0 : 2'd1);
    chk("ovr_sat", u_if.ovr_cnt, OVR_ON ? 8'd255 : 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/modulo_escalonador_divisor.md
# modulo_escalonador_divisor

Synchronous scheduler that owns the ripple frequency divider: it drives the divider's clear, resynchronises the divider's `clk_div` output into the system clock domain, and shares each divided-clock tick among up to `N_REQ` requesters in round-robin order. It sits between the divider and the slow-rate consumers (display multiplexing, debounce, timers), so no consumer ever clocks logic from `clk_div` directly.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `RESTART_CYC`, 2, cycles `div_clr` is held low on (re)start (≥1)
- `SYNC_STAGES`, 2, synchroniser depth for `clk_div` (≥2)
- `clk`  in  1  system clock; the only clock in the block
- `clr`  in  1  reset, synchronous, active-low
- `en`  in  1  run enable; low = stop and hold divider cleared
- `clk_div`  in  1  divider output; asynchronous to `clk`
- `div_clr`  out  1  divider clear, active-low (0 = divider held in clear)
- `req`  in  N_REQ  per-requester level request
- `gnt`  out  N_REQ  one-hot grant, one `clk` cycle wide
- `gnt_id`  out  $clog2(N_REQ)  index of the last granted requester
- `tick`  out  1  one-cycle pulse per rising edge of `clk_div` while in RUN
- `busy`  out  1  high in every state except IDLE
- `ovr_cnt`  out  8  overrun count (see Configuration)

## Operation
- States: IDLE → RESTART → ALIGN → RUN.
- IDLE: `div_clr`=0, `busy`=0. `en`=1 → RESTART.
- RESTART: `div_clr`=0 for exactly `RESTART_CYC` cycles, then ALIGN; synchroniser and edge detector flushed to 0.
- ALIGN: `div_clr`=1. First detected rising edge of synchronised `clk_div` → RUN; that edge produces no `tick` and no grant.
- RUN: every detected rising edge asserts `tick` for one cycle. In the same cycle, if `req`≠0, `gnt` asserts the first set bit at or after pointer `ptr` (search wraps N_REQ-1 → 0); `gnt_id` loads that index; `ptr` ← index+1 modulo N_REQ. If `req`=0, `tick` only, `ptr` unchanged.
- `en`=0 in any state → IDLE on next edge; `gnt`,`tick` forced 0 that cycle; `ptr` ← 0; `gnt_id` holds.
- `req` is sampled only on the edge that registers `tick`; requests asserted and dropped between ticks are never granted.
- Single requester active: granted on every tick.
- Reset values: state IDLE, `div_clr`=0, `gnt`=0, `gnt_id`=0, `tick`=0, `busy`=0, `ovr_cnt`=0, `ptr`=0, synchroniser 0.
- `clr` low mid-operation: all registers to reset values on that edge regardless of state.

## Timing
- `clk_div` rising level first captured at edge E0 → `tick`/`gnt` high in the cycle after edge E0+`SYNC_STAGES` (all outputs registered).
- `gnt` and `tick` are coincident and one cycle wide; `gnt` never asserts without `tick`.
- `en` rising at edge E → `div_clr` low from E+1 through E+`RESTART_CYC`, high from E+`RESTART_CYC`+1.
- Minimum `clk_div` high and low time: `SYNC_STAGES`+1 `clk` cycles; shorter pulses may be lost (not detected, no error).

## Configuration
- `ESCALONADOR_OVERRUN_EN` defined: on every RUN tick where `req` has more than one bit set, `ovr_cnt` increments, saturating at 255; cleared by `clr` and on entry to IDLE.
- Not defined: counter logic absent, `ovr_cnt` tied to 0.

## Structure
- Package `modulo_escalonador_pkg`: state enum (IDLE, RESTART, ALIGN, RUN), `OVR_MAX`=255, `OVR_W`=8.
- Sub-module `modulo_sincronizador`: `SYNC_STAGES`-deep flip-flop chain plus registered rising-edge detect, synchronous active-low `clr`, flush input.

## Test plan
- `clr`=0 two cycles then `en`=1 → `div_clr` low exactly 2 cycles, `busy`=1, first `clk_div` rise gives no `tick`, second gives `tick` at E0+3.
- `req`=4'b1111 over 8 ticks → `gnt` sequence 0001,0010,0100,1000,0001,…; `gnt_id` 0,1,2,3,0; `ovr_cnt`=8 with macro, 0 without.
- `req`=4'b1010, `ptr`=0 → grants 0010,1000,0010; `req`=0 on a tick → `tick`=1, `gnt`=0, next grant resumes at stored `ptr`.
- `en` dropped in RUN in the same cycle a tick would fire → no `tick`/`gnt`, next cycle IDLE, `div_clr`=0, `ptr`=0; re-enable repeats RESTART/ALIGN.
- `clr` low mid-RUN with `ovr_cnt`=37 → all outputs to reset values next edge, `ovr_cnt`=0.
- 300 ticks with `req`=4'b0011 and macro defined → `ovr_cnt` saturates at 255.
